// File: rtl/ring_mon_pkg.sv
`default_nettype none
// ring_mon_pkg: shared state encoding, default sizes and the rotate-right helper
// for the ring phase monitor.
package ring_mon_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_LOCK_CNT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    ERR    = 2'd3
  } ring_state_e;

  // Rotate right by one within the low 'width' bits; bits above 'width' must be zero.
  function automatic logic [63:0] rotr(input logic [63:0] w, input int unsigned width);
    return (w >> 1) | ({63'b0, w[0]} << (width - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ring_phase_monitor_if.sv
`default_nettype none
// ring_phase_monitor_if: sample enable / phase word in, decoded slot and health status out.
interface ring_phase_monitor_if
  import ring_mon_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int REV_W = 16,
  parameter int ERR_W = 8
);
  localparam int IDX_W = $clog2(WIDTH);

  logic             en;
  logic [WIDTH-1:0] phase_in;
  logic [IDX_W-1:0] slot_idx;
  logic             slot_valid;
  logic             locked;
  logic             rev_tick;
  logic [REV_W-1:0] rev_count;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [WIDTH-1:0] err_seen;
  logic [WIDTH-1:0] err_exp;

  modport slave (
    input  en, phase_in,
    output slot_idx, slot_valid, locked, rev_tick, rev_count,
           err_pulse, err_count, err_seen, err_exp
  );

  modport master (
    output en, phase_in,
    input  slot_idx, slot_valid, locked, rev_tick, rev_count,
           err_pulse, err_count, err_seen, err_exp
  );
endinterface
`default_nettype wire

// File: rtl/onehot_encoder.sv
`default_nettype none
// onehot_encoder: flags a word with exactly one bit set and returns that bit's index.
module onehot_encoder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]         word_i,
  output logic                     is_onehot_o,
  output logic [$clog2(WIDTH)-1:0] idx_o
);
  localparam int IDX_W = $clog2(WIDTH);

  assign is_onehot_o = (word_i != '0) && ((word_i & (word_i - 1'b1)) == '0);

  // OR of set-bit indices; exact whenever the word is one-hot
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (word_i[i]) idx_o = idx_o | IDX_W'(i);
    end
  end
endmodule
`default_nettype wire

// File: rtl/ring_phase_monitor.sv
`default_nettype none
// ring_phase_monitor: validates a rotating one-hot phase word, locks onto it, counts
// revolutions and sequence errors. RING_ERR_CAPTURE_EN adds capture of the failing words.
module ring_phase_monitor
  import ring_mon_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int REV_W    = 16,
  parameter int ERR_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  ring_phase_monitor_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam int GC_W  = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam logic [GC_W-1:0] GC_LAST = GC_W'(LOCK_CNT - 1);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_ACQ    = ACQ;
  localparam logic [1:0] S_LOCKED = LOCKED;
  localparam logic [1:0] S_ERR    = ERR;

  logic             w_onehot;
  logic [IDX_W-1:0] w_idx;
  logic [WIDTH-1:0] w_exp;
  logic             w_step_ok;

  logic [1:0]       state_q, state_d;
  logic [GC_W-1:0]  good_cnt_q, good_cnt_d;
  logic [WIDTH-1:0] prev_q;
  logic [IDX_W-1:0] slot_idx_q;
  logic             slot_valid_q;
  logic             locked_q;
  logic             rev_tick_q, rev_tick_d;
  logic [REV_W-1:0] rev_count_q, rev_count_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  onehot_encoder #(.WIDTH(WIDTH)) u_enc (
    .word_i      (bus.phase_in),
    .is_onehot_o (w_onehot),
    .idx_o       (w_idx)
  );

  assign w_exp     = WIDTH'(rotr(64'(prev_q), WIDTH));
  assign w_step_ok = w_onehot && (bus.phase_in == w_exp);

  always_comb begin
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    rev_count_d = rev_count_q;
    err_count_d = err_count_q;
    rev_tick_d  = 1'b0;
    err_pulse_d = 1'b0;
    if (bus.en) begin
      case (state_q)
        S_IDLE: begin
          if (w_onehot) begin
            state_d    = S_ACQ;
            good_cnt_d = '0;
          end
        end
        S_ACQ: begin
          if (w_step_ok) begin
            if (good_cnt_q == GC_LAST) state_d = S_LOCKED;
            else                       good_cnt_d = good_cnt_q + 1'b1;
          end else if (w_onehot) begin
            good_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LOCKED: begin
          if (w_step_ok) begin
            // bit 0 rotating back to the MSB closes one revolution
            if (prev_q[0]) begin
              rev_tick_d  = 1'b1;
              rev_count_d = rev_count_q + 1'b1;
            end
          end else begin
            state_d     = S_ERR;
            err_pulse_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
          end
        end
        default: begin
          good_cnt_d = '0;
          state_d    = w_onehot ? S_ACQ : S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      good_cnt_q   <= '0;
      prev_q       <= '0;
      slot_idx_q   <= '0;
      slot_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      rev_tick_q   <= 1'b0;
      rev_count_q  <= '0;
      err_pulse_q  <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      locked_q    <= (state_d == S_LOCKED);
      rev_tick_q  <= rev_tick_d;
      rev_count_q <= rev_count_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
      if (bus.en) begin
        prev_q       <= bus.phase_in;
        slot_valid_q <= w_onehot;
        if (w_onehot) slot_idx_q <= w_idx;
      end
    end
  end

  assign bus.slot_idx   = slot_idx_q;
  assign bus.slot_valid = slot_valid_q;
  assign bus.locked     = locked_q;
  assign bus.rev_tick   = rev_tick_q;
  assign bus.rev_count  = rev_count_q;
  assign bus.err_pulse  = err_pulse_q;
  assign bus.err_count  = err_count_q;

`ifdef RING_ERR_CAPTURE_EN
  logic [WIDTH-1:0] err_seen_q;
  logic [WIDTH-1:0] err_exp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_seen_q <= '0;
      err_exp_q  <= '0;
    end else if (err_pulse_d) begin
      err_seen_q <= bus.phase_in;
      err_exp_q  <= w_exp;
    end
  end

  assign bus.err_seen = err_seen_q;
  assign bus.err_exp  = err_exp_q;
`else
  assign bus.err_seen = '0;
  assign bus.err_exp  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ring_phase_monitor.sv
`default_nettype none
// tb_ring_phase_monitor: directed plan plus randomized phase words against a reference model.
module tb_ring_phase_monitor;
  localparam int W    = 8;
  localparam int LOCK = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ring_phase_monitor_if #(.WIDTH(W), .REV_W(16), .ERR_W(8)) bus ();

  ring_phase_monitor #(.WIDTH(W), .LOCK_CNT(LOCK), .REV_W(16), .ERR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: mode is a plain string, counters are unbounded ints reduced at compare time
  string    m_mode;
  int       m_good;
  logic [W-1:0] m_prev;
  int       m_idx;
  bit       m_valid, m_tick, m_pulse;
  int       m_rev, m_err;
  logic [W-1:0] m_seen, m_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = "IDLE"; m_good = 0; m_prev = '0; m_idx = 0; m_valid = 0;
    m_tick = 0; m_pulse = 0; m_rev = 0; m_err = 0; m_seen = '0; m_exp = '0;
  endtask

  task automatic model_step(input bit e, input logic [W-1:0] p);
    bit oh, ok;
    logic [W-1:0] ex;
    m_tick  = 0;
    m_pulse = 0;
    if (!e) return;
    oh = ($countones(p) == 1);
    ex = {m_prev[0], m_prev[W-1:1]};
    ok = oh && (p == ex);
    if (m_mode == "IDLE") begin
      if (oh) begin m_mode = "ACQ"; m_good = 0; end
    end else if (m_mode == "ACQ") begin
      if (ok) begin
        m_good++;
        if (m_good == LOCK) m_mode = "LOCKED";
      end else if (oh) m_good = 0;
      else m_mode = "IDLE";
    end else if (m_mode == "LOCKED") begin
      if (ok) begin
        if (m_prev[0]) begin m_tick = 1; m_rev++; end
      end else begin
        m_mode = "ERR"; m_pulse = 1;
        if (m_err < 255) m_err++;
        m_seen = p; m_exp = ex;
      end
    end else begin
      m_good = 0;
      m_mode = oh ? "ACQ" : "IDLE";
    end
    m_prev  = p;
    m_valid = oh;
    if (oh) for (int i = 0; i < W; i++) if (p[i]) m_idx = i;
  endtask

  task automatic check_all();
    check("slot_idx",   32'(bus.slot_idx),   32'(m_idx));
    check("slot_valid", 32'(bus.slot_valid), 32'(m_valid));
    check("locked",     32'(bus.locked),     32'(m_mode == "LOCKED"));
    check("rev_tick",   32'(bus.rev_tick),   32'(m_tick));
    check("rev_count",  32'(bus.rev_count),  32'(m_rev % 65536));
    check("err_pulse",  32'(bus.err_pulse),  32'(m_pulse));
    check("err_count",  32'(bus.err_count),  32'(m_err));
`ifdef RING_ERR_CAPTURE_EN
    check("err_seen",   32'(bus.err_seen),   32'(m_seen));
    check("err_exp",    32'(bus.err_exp),    32'(m_exp));
`else
    check("err_seen",   32'(bus.err_seen),   32'h0);
    check("err_exp",    32'(bus.err_exp),    32'h0);
`endif
  endtask

  task automatic step(input bit e, input logic [W-1:0] p);
    bus.en       = e;
    bus.phase_in = p;
    @(posedge clk);
    model_step(e, p);
    @(negedge clk);
    check_all();
  endtask

  task automatic lock_seq();
    step(1, 8'h80); step(1, 8'h40); step(1, 8'h20); step(1, 8'h10);
    check("locked_before_4th", 32'(bus.locked), 32'h0);
    step(1, 8'h08);
    check("locked_after_08", 32'(bus.locked), 32'h1);
    check("idx_after_08", 32'(bus.slot_idx), 32'd3);
  endtask

  initial begin
    logic [W-1:0] nxt;
    int r;
    bus.en = 1'b0;
    bus.phase_in = '0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    lock_seq();
    step(1, 8'h04); step(1, 8'h02); step(1, 8'h01); step(1, 8'h80);
    check("rev_tick_wrap", 32'(bus.rev_tick), 32'h1);
    check("rev_count_one", 32'(bus.rev_count), 32'h1);

    step(1, 8'h20);
    check("err_pulse_on", 32'(bus.err_pulse), 32'h1);
    check("err_count_one", 32'(bus.err_count), 32'h1);
    check("unlocked_on_err", 32'(bus.locked), 32'h0);
`ifdef RING_ERR_CAPTURE_EN
    check("seen_20", 32'(bus.err_seen), 32'h20);
    check("exp_40", 32'(bus.err_exp), 32'h40);
`endif

    step(1, 8'h00);
    step(1, 8'h81);
    check("idx_hold", 32'(bus.slot_idx), 32'd5);
    check("valid_low", 32'(bus.slot_valid), 32'h0);
    lock_seq();

    for (int i = 0; i < 3; i++) step(0, 8'($urandom));
    step(1, 8'h04);
    check("locked_after_hold", 32'(bus.locked), 32'h1);

    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 75)      nxt = (m_prev == '0) ? 8'h80 : {m_prev[0], m_prev[W-1:1]};
      else if (r < 85) nxt = 8'(1) << $urandom_range(0, W - 1);
      else if (r < 93) nxt = 8'($urandom);
      else             nxt = m_prev;
      step($urandom_range(0, 9) != 0, nxt);
    end

    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    lock_seq();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
